// File: rtl/crg_clk_seq.sv
// crg_clk_seq: clock-enable / clk1-select sequencer ahead of the CRG.
// Waits for stable MMCM lock, ramps gates on one by one, gates clk1 around mux switches.
module crg_clk_seq #(
  parameter int NUM_CLK   = 4,
  parameter int LOCK_WAIT = 1024,
  parameter int STAGGER   = 16,
  parameter int SW_GAP    = 8,
  parameter int CNT_W     = 16
) (
  input  logic               clk_src,
  input  logic               rst_n_sys,
  input  logic               mmcm_locked,
  input  logic [NUM_CLK-1:0] en_req,
  input  logic               sel_req,
  input  logic               lock_lost_clr,
  output logic [NUM_CLK-1:0] clk_en,
  output logic               clk1_sel,
  output logic               ready,
  output logic               switch_busy,
  output logic               lock_lost
);

  localparam int IDX_W = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

  localparam logic [CNT_W-1:0] LW_END = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] ST_END = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] SG_END = CNT_W'(SW_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLK - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    RAMP,
    RUN,
    SW_PRE,
    SW_POST
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CLK-1:0] en_q, en_d;
  logic               sel_q, sel_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               lost_q, lost_d;
  logic               meta_q, locked_q;
  logic               clocks_live;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk_src) begin
    if (!rst_n_sys) begin
      meta_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      meta_q   <= mmcm_locked;
      locked_q <= meta_q;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_src) begin
    if (!rst_n_sys) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      sel_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      lost_q  <= lost_d;
    end
  end

  assign clocks_live = (state_q == RAMP) || (state_q == RUN) ||
                       (state_q == SW_PRE) || (state_q == SW_POST);

  // Next-state logic; lock loss overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    en_d    = en_q;
    sel_d   = sel_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    lost_d  = lost_q & ~lock_lost_clr;

    unique case (state_q)
      WAIT_LOCK: begin
        en_d = '0;
        if (locked_q) begin
          cnt_d   = '0;
          state_d = STABLE;
        end
      end
      STABLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!locked_q) begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end else if (cnt_q == LW_END) begin
          sel_d   = sel_req;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = RAMP;
        end
      end
      RAMP: begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int i = 0; i < NUM_CLK; i++) begin
          if (IDX_W'(i) < idx_q) en_d[i] = en_req[i];
        end
        if (cnt_q == ST_END) begin
          en_d[idx_q] = en_req[idx_q];
          cnt_d       = '0;
          idx_d       = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            ready_d = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        en_d = en_req;
        if (sel_req != sel_q) begin
          en_d[1] = 1'b0;
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SW_PRE;
        end
      end
      SW_PRE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        en_d    = en_req;
        en_d[1] = 1'b0;
        if (cnt_q == SG_END) begin
          sel_d   = sel_req;
          cnt_d   = '0;
          state_d = SW_POST;
        end
      end
      SW_POST: begin
        cnt_d   = cnt_q + CNT_W'(1);
        en_d    = en_req;
        en_d[1] = 1'b0;
        if (cnt_q == SG_END) begin
          en_d[1] = en_req[1];
          cnt_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        en_d    = '0;
        cnt_d   = '0;
        state_d = WAIT_LOCK;
      end
    endcase

    if (clocks_live && !locked_q) begin
      en_d    = '0;
      cnt_d   = '0;
      idx_d   = '0;
      ready_d = 1'b0;
      busy_d  = 1'b0;
      lost_d  = 1'b1;
      state_d = WAIT_LOCK;
    end
  end

  assign clk_en      = en_q;
  assign clk1_sel    = sel_q;
  assign ready       = ready_q;
  assign switch_busy = busy_q;
  assign lock_lost   = lost_q;

endmodule

// File: tb/tb_crg_clk_seq.sv
// tb_crg_clk_seq: directed bench for the clock-enable sequencer.
// Short LOCK_WAIT/STAGGER/SW_GAP keep the hand-counted edges small.
module tb_crg_clk_seq;

  logic       clk_src;
  logic       rst_n_sys;
  logic       mmcm_locked;
  logic [3:0] en_req;
  logic       sel_req;
  logic       lock_lost_clr;
  logic [3:0] clk_en;
  logic       clk1_sel;
  logic       ready;
  logic       switch_busy;
  logic       lock_lost;

  int errors = 0;
  int checks = 0;

  crg_clk_seq #(
    .NUM_CLK  (4),
    .LOCK_WAIT(8),
    .STAGGER  (4),
    .SW_GAP   (3),
    .CNT_W    (16)
  ) dut (
    .clk_src      (clk_src),
    .rst_n_sys    (rst_n_sys),
    .mmcm_locked  (mmcm_locked),
    .en_req       (en_req),
    .sel_req      (sel_req),
    .lock_lost_clr(lock_lost_clr),
    .clk_en       (clk_en),
    .clk1_sel     (clk1_sel),
    .ready        (ready),
    .switch_busy  (switch_busy),
    .lock_lost    (lock_lost)
  );

  initial clk_src = 1'b0;
  always #5 clk_src = ~clk_src;

  task automatic tick();
    @(posedge clk_src);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Caller raises lock right after edge 0; checks edges 1..27.
  task automatic ramp(input logic [3:0] req,
                      input logic s0,
                      input logic s1);
    logic [3:0] exp;
    for (int e = 1; e <= 27; e++) begin
      tick();
      for (int i = 0; i < 4; i++)
        exp[i] = req[i] & (e >= 15 + 4 * i);
      chk("ramp_en", 32'(clk_en), 32'(exp));
      chk("ramp_rdy", 32'(ready), 32'(e >= 27));
      chk("ramp_sel", 32'(clk1_sel), 32'(e >= 11 ? s1 : s0));
      chk("ramp_lost", 32'(lock_lost), 32'(0));
    end
  endtask

  initial begin
    rst_n_sys     = 1'b0;
    mmcm_locked   = 1'b0;
    en_req        = 4'b1111;
    sel_req       = 1'b0;
    lock_lost_clr = 1'b0;

    tick(); tick(); tick();
    chk("rst_en", 32'(clk_en), 32'(0));
    chk("rst_sel", 32'(clk1_sel), 32'(0));
    chk("rst_rdy", 32'(ready), 32'(0));
    chk("rst_busy", 32'(switch_busy), 32'(0));
    chk("rst_lost", 32'(lock_lost), 32'(0));
    rst_n_sys = 1'b1;
    tick(); tick();
    chk("idle_en", 32'(clk_en), 32'(0));

    mmcm_locked = 1'b1;
    ramp(4'b1111, 1'b0, 1'b0);

    sel_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("sw_en1", 32'(clk_en[1]), 32'(k >= 7));
      chk("sw_other", 32'({clk_en[3:2], clk_en[0]}), 32'(3'b111));
      chk("sw_sel", 32'(clk1_sel), 32'(k >= 4));
      chk("sw_busy", 32'(switch_busy), 32'(k <= 6));
      chk("sw_rdy", 32'(ready), 32'(k >= 7));
    end
    tick();
    chk("sw_done_en", 32'(clk_en), 32'(4'b1111));
    chk("sw_done_busy", 32'(switch_busy), 32'(0));

    mmcm_locked = 1'b0;
    tick(); tick();
    chk("ll_pre_en", 32'(clk_en), 32'(4'b1111));
    chk("ll_pre_lost", 32'(lock_lost), 32'(0));
    tick();
    chk("ll_en", 32'(clk_en), 32'(0));
    chk("ll_rdy", 32'(ready), 32'(0));
    chk("ll_lost", 32'(lock_lost), 32'(1));
    chk("ll_sel", 32'(clk1_sel), 32'(1));
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    chk("clr_lost", 32'(lock_lost), 32'(0));

    mmcm_locked = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("gl_hi_en", 32'(clk_en), 32'(0));
    end
    mmcm_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("gl_lo_en", 32'(clk_en), 32'(0));
      chk("gl_lost", 32'(lock_lost), 32'(0));
    end
    mmcm_locked = 1'b1;
    ramp(4'b1111, 1'b1, 1'b1);

    rst_n_sys   = 1'b0;
    mmcm_locked = 1'b0;
    sel_req     = 1'b0;
    tick(); tick();
    rst_n_sys = 1'b1;
    en_req    = 4'b0101;
    tick(); tick();
    mmcm_locked = 1'b1;
    ramp(4'b0101, 1'b0, 1'b0);
    en_req = 4'b1101;
    tick();
    chk("run_en3", 32'(clk_en), 32'(4'b1101));
    en_req = 4'b1111;
    tick();
    chk("run_en1", 32'(clk_en), 32'(4'b1111));

    sel_req = 1'b1;
    tick();
    chk("pre_en", 32'(clk_en), 32'(4'b1101));
    chk("pre_busy", 32'(switch_busy), 32'(1));
    tick();
    rst_n_sys = 1'b0;
    tick();
    chk("mid_rst_en", 32'(clk_en), 32'(0));
    chk("mid_rst_sel", 32'(clk1_sel), 32'(0));
    chk("mid_rst_rdy", 32'(ready), 32'(0));
    chk("mid_rst_busy", 32'(switch_busy), 32'(0));
    chk("mid_rst_lost", 32'(lock_lost), 32'(0));
    rst_n_sys = 1'b1;
    ramp(4'b1111, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crg_clk_seq.md
Name: crg_clk_seq

Overview:
- Clock-enable and clock-select sequencer that sits directly upstream of the CRG.
- Drives the CRG's gate enables (clk_phy_en, clk1_en, clk2_en, clk3_en) and the clk1 mux select (clk1_sel).
- Holds all output clocks off until MMCM lock has been stable for a programmable time, then turns them on one at a time, staggered.
- Switches the clk1 mux only while clk1 is gated, and drops every enable immediately if lock is lost.

Parameters:
- NUM_CLK, 4, number of gated clocks. Bit order: 0 = clk_phy, 1 = clk1, 2 = clk2, 3 = clk3.
- LOCK_WAIT, 1024, cycles locked must stay high before ramp-up begins.
- STAGGER, 16, cycles between successive enable steps during ramp-up.
- SW_GAP, 8, gated cycles before and after a clk1_sel change.
- CNT_W, 16, counter width. Constraint: LOCK_WAIT, STAGGER and SW_GAP each lie in the range 1 to 2^CNT_W-1.

Ports:
- clk_src, in, 1: free-running reference clock; the only clock.
- rst_n_sys, in, 1: reset, synchronous, active-low.
- mmcm_locked, in, 1: MMCM locked, asynchronous; synchronised internally with 2 flops.
- en_req, in, NUM_CLK: requested enable per clock.
- sel_req, in, 1: requested clk1 mux select.
- lock_lost_clr, in, 1: clears lock_lost.
- clk_en, out, NUM_CLK: gate enables to the CRG.
- clk1_sel, out, 1: mux select to the CRG.
- ready, out, 1: high while in RUN.
- switch_busy, out, 1: high while a clk1 switch is in progress.
- lock_lost, out, 1: sticky flag, lock dropped after ramp-up started.

Behaviour:
- All outputs are registered.
- Reset (rst_n_sys = 0 at an edge): clk_en = 0, clk1_sel = 0, ready = 0, switch_busy = 0, lock_lost = 0, counters = 0, sync flops = 0, state = WAIT_LOCK. Reset mid-operation takes effect on that same edge.
- locked_s: 2-flop synchronised mmcm_locked. It lags the input by 2 edges.
- WAIT_LOCK: clk_en = 0. When locked_s = 1: cnt <= 0, go to STABLE.
- STABLE:
  - cnt increments every cycle.
  - If locked_s = 0: go to WAIT_LOCK; lock_lost is not set.
  - At cnt == LOCK_WAIT-1: clk1_sel <= sel_req, idx <= 0, cnt <= 0, go to RAMP.
- RAMP:
  - cnt increments every cycle.
  - At cnt == STAGGER-1: clk_en[idx] <= en_req[idx], idx++, cnt <= 0. A step where en_req[idx] = 0 still consumes STAGGER cycles.
  - When idx == NUM_CLK-1 completes: go to RUN and set ready <= 1 on the same edge.
  - Bits already enabled track en_req with 1-cycle latency.
- RUN:
  - clk_en <= en_req every cycle (1-cycle latency).
  - If sel_req != clk1_sel: clk_en[1] <= 0, cnt <= 0, ready <= 0, switch_busy <= 1, go to SW_PRE. A sel_req mismatch takes priority over the en_req[1] update on that edge.
- SW_PRE:
  - clk_en[1] is held 0; the other bits keep tracking en_req.
  - At cnt == SW_GAP-1: clk1_sel <= sel_req (re-sampled), cnt <= 0, go to SW_POST.
- SW_POST:
  - clk_en[1] is held 0.
  - At cnt == SW_GAP-1: clk_en[1] <= en_req[1], switch_busy <= 0, ready <= 1, go to RUN.
  - If sel_req changed again during the switch, RUN starts a new switch on its next evaluation.
- Lock loss (locked_s = 0 in RAMP, RUN, SW_PRE or SW_POST):
  - Next edge: clk_en = 0, ready = 0, switch_busy = 0, lock_lost <= 1, go to WAIT_LOCK.
  - clk1_sel holds its value.
  - Lock loss has priority over every other transition.
- lock_lost: cleared by lock_lost_clr = 1. If a set and a clear occur on the same edge, the set wins.
- clk1_sel never changes while clk_en[1] = 1.
- Counters never wrap: they are cleared on every state transition.

Test Plan (LOCK_WAIT = 8, STAGGER = 4, SW_GAP = 3, en_req = 4'b1111, sel_req = 0; edge 0 is the first edge with mmcm_locked = 1):
- Power-up ramp -> clk_en[0] rises at edge 15, [1] at 19, [2] at 23, [3] at 27. ready = 1 at edge 27. clk1_sel = 0 throughout.
- Lock glitch: mmcm_locked low for 3 cycles during STABLE -> clk_en stays 0, lock_lost stays 0, ramp restarts with the full LOCK_WAIT.
- In RUN, sel_req 0 -> 1, first seen at edge e -> clk_en[1] = 0 at e+1, clk1_sel = 1 at e+4, clk_en[1] = 1 at e+7. switch_busy = 1 over edges e+1 to e+6. clk_en[0], [2], [3] stay 1.
- In RUN, mmcm_locked drops -> 3 edges later clk_en = 0, ready = 0, lock_lost = 1. Pulse lock_lost_clr -> lock_lost = 0. Relock -> full ramp repeats.
- en_req = 4'b0101 at power-up -> clk_en = 4'b0101 at edge 27, ready at edge 27. Then en_req[3] = 1 in RUN -> clk_en[3] = 1 one edge later.
- rst_n_sys = 0 in SW_PRE -> on that edge all outputs = 0, clk1_sel = 0, state = WAIT_LOCK.
